// File: rtl/cpu_pkg.sv
// Shared CPU constants, control-field widths and the D->E stage payload layout.
package cpu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned VLEN  = 128;
   localparam int unsigned RADDR = 6;

   localparam int unsigned RESULT_SOURCE_W  = 2;
   localparam int unsigned WIDTH_TYPE_W     = 3;
   localparam int unsigned ALU_OP_W         = 4;
   localparam int unsigned COND_CODE_W      = 3;
   localparam int unsigned REROUTING_CODE_W = 3;

   // Full decode/execute stage payload, one field per pipeline-register slice
   typedef struct packed {
      logic [XLEN-1:0]             instruction;
      logic                        write_scalar_reg;
      logic [RESULT_SOURCE_W-1:0]  result_source;
      logic [WIDTH_TYPE_W-1:0]     width_type;
      logic                        mem_write;
      logic [ALU_OP_W-1:0]         ALU_op;
      logic [COND_CODE_W-1:0]      cond_code;
      logic                        ALU_source;
      logic                        branch;
      logic                        jump;
      logic                        i_jump;
      logic                        PC_to_ALU;
      logic                        memory_transaction;
      logic                        write_vector_reg;
      logic                        select_operand_0_vector;
      logic                        select_operand_1_vector;
      logic                        rerouting_select;
      logic [REROUTING_CODE_W-1:0] rerouting_code;
      logic [RADDR-1:0]            rd;
      logic [RADDR-1:0]            r1;
      logic [RADDR-1:0]            r2;
      logic [XLEN-1:0]             scalar_reg_data_0;
      logic [XLEN-1:0]             scalar_reg_data_1;
      logic [VLEN-1:0]             vector_reg_data_0;
      logic [VLEN-1:0]             vector_reg_data_1;
      logic [XLEN-1:0]             immediate;
      logic [XLEN-1:0]             PC;
      logic [XLEN-1:0]             PC_plus_4;
   } de_fields_t;

endpackage

// File: rtl/pipe_execute_vp_reg_if.sv
// Decode->execute stage bus: decode-side fields, execute-side fields and stall/flush controls.
interface pipe_execute_vp_reg_if;
   import cpu_pkg::*;

   logic                        sync_reset;
   logic                        enabler;

   logic [XLEN-1:0]             instruction_D,             instruction_E;
   logic                        write_scalar_reg_D,        write_scalar_reg_E;
   logic [RESULT_SOURCE_W-1:0]  result_source_D,           result_source_E;
   logic [WIDTH_TYPE_W-1:0]     width_type_D,              width_type_E;
   logic                        mem_write_D,               mem_write_E;
   logic [ALU_OP_W-1:0]         ALU_op_D,                  ALU_op_E;
   logic [COND_CODE_W-1:0]      cond_code_D,               cond_code_E;
   logic                        ALU_source_D,              ALU_source_E;
   logic                        branch_D,                  branch_E;
   logic                        jump_D,                    jump_E;
   logic                        i_jump_D,                  i_jump_E;
   logic                        PC_to_ALU_D,               PC_to_ALU_E;
   logic                        memory_transaction_D,      memory_transaction_E;
   logic                        write_vector_reg_D,        write_vector_reg_E;
   logic                        select_operand_0_vector_D, select_operand_0_vector_E;
   logic                        select_operand_1_vector_D, select_operand_1_vector_E;
   logic                        rerouting_select_D,        rerouting_select_E;
   logic [REROUTING_CODE_W-1:0] rerouting_code_D,          rerouting_code_E;
   logic [RADDR-1:0]            rd_D,                      rd_E;
   logic [RADDR-1:0]            r1_D,                      r1_E;
   logic [RADDR-1:0]            r2_D,                      r2_E;
   logic [XLEN-1:0]             scalar_reg_data_0_D,       scalar_reg_data_0_E;
   logic [XLEN-1:0]             scalar_reg_data_1_D,       scalar_reg_data_1_E;
   logic [VLEN-1:0]             vector_reg_data_0_D,       vector_reg_data_0_E;
   logic [VLEN-1:0]             vector_reg_data_1_D,       vector_reg_data_1_E;
   logic [XLEN-1:0]             immediate_D,               immediate_E;
   logic [XLEN-1:0]             PC_D,                      PC_E;
   logic [XLEN-1:0]             PC_plus_4_D,               PC_plus_4_E;

   // Decode stage / hazard unit side
   modport master (
      output sync_reset, enabler,
      output instruction_D, write_scalar_reg_D, result_source_D, width_type_D, mem_write_D,
             ALU_op_D, cond_code_D, ALU_source_D, branch_D, jump_D, i_jump_D, PC_to_ALU_D,
             memory_transaction_D, write_vector_reg_D, select_operand_0_vector_D,
             select_operand_1_vector_D, rerouting_select_D, rerouting_code_D, rd_D, r1_D, r2_D,
             scalar_reg_data_0_D, scalar_reg_data_1_D, vector_reg_data_0_D, vector_reg_data_1_D,
             immediate_D, PC_D, PC_plus_4_D,
      input  instruction_E, write_scalar_reg_E, result_source_E, width_type_E, mem_write_E,
             ALU_op_E, cond_code_E, ALU_source_E, branch_E, jump_E, i_jump_E, PC_to_ALU_E,
             memory_transaction_E, write_vector_reg_E, select_operand_0_vector_E,
             select_operand_1_vector_E, rerouting_select_E, rerouting_code_E, rd_E, r1_E, r2_E,
             scalar_reg_data_0_E, scalar_reg_data_1_E, vector_reg_data_0_E, vector_reg_data_1_E,
             immediate_E, PC_E, PC_plus_4_E
   );

   // Pipeline register side
   modport slave (
      input  sync_reset, enabler,
      input  instruction_D, write_scalar_reg_D, result_source_D, width_type_D, mem_write_D,
             ALU_op_D, cond_code_D, ALU_source_D, branch_D, jump_D, i_jump_D, PC_to_ALU_D,
             memory_transaction_D, write_vector_reg_D, select_operand_0_vector_D,
             select_operand_1_vector_D, rerouting_select_D, rerouting_code_D, rd_D, r1_D, r2_D,
             scalar_reg_data_0_D, scalar_reg_data_1_D, vector_reg_data_0_D, vector_reg_data_1_D,
             immediate_D, PC_D, PC_plus_4_D,
      output instruction_E, write_scalar_reg_E, result_source_E, width_type_E, mem_write_E,
             ALU_op_E, cond_code_E, ALU_source_E, branch_E, jump_E, i_jump_E, PC_to_ALU_E,
             memory_transaction_E, write_vector_reg_E, select_operand_0_vector_E,
             select_operand_1_vector_E, rerouting_select_E, rerouting_code_E, rd_E, r1_E, r2_E,
             scalar_reg_data_0_E, scalar_reg_data_1_E, vector_reg_data_0_E, vector_reg_data_1_E,
             immediate_E, PC_E, PC_plus_4_E
   );

endinterface

// File: rtl/pipe_field_reg.sv
// One pipeline-register slice: async clear, then flush, then load-on-enable, else hold.
module pipe_field_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             async_reset,
   input  logic             sync_clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Flush wins over stall so a bubble can be inserted into a stalled stage
   always_ff @(posedge clock or posedge async_reset) begin
      if (async_reset)     q <= '0;
      else if (sync_clear) q <= '0;
      else if (enable)     q <= d;
   end

endmodule

// File: rtl/pipe_execute_vp_reg.sv
// Decode->execute pipeline register; every field shares the same enable/flush so the stage moves as a unit.
module pipe_execute_vp_reg
   import cpu_pkg::*;
(
   input logic                   clock,
   input logic                   async_reset,
   pipe_execute_vp_reg_if.slave  bus
);

   pipe_field_reg #(.WIDTH(XLEN)) u_instruction (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.instruction_D), .q(bus.instruction_E));
   pipe_field_reg #(.WIDTH(1)) u_write_scalar_reg (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.write_scalar_reg_D), .q(bus.write_scalar_reg_E));
   pipe_field_reg #(.WIDTH(RESULT_SOURCE_W)) u_result_source (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.result_source_D), .q(bus.result_source_E));
   pipe_field_reg #(.WIDTH(WIDTH_TYPE_W)) u_width_type (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.width_type_D), .q(bus.width_type_E));
   pipe_field_reg #(.WIDTH(1)) u_mem_write (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.mem_write_D), .q(bus.mem_write_E));
   pipe_field_reg #(.WIDTH(ALU_OP_W)) u_ALU_op (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.ALU_op_D), .q(bus.ALU_op_E));
   pipe_field_reg #(.WIDTH(COND_CODE_W)) u_cond_code (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.cond_code_D), .q(bus.cond_code_E));
   pipe_field_reg #(.WIDTH(1)) u_ALU_source (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.ALU_source_D), .q(bus.ALU_source_E));
   pipe_field_reg #(.WIDTH(1)) u_branch (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.branch_D), .q(bus.branch_E));
   pipe_field_reg #(.WIDTH(1)) u_jump (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.jump_D), .q(bus.jump_E));
   pipe_field_reg #(.WIDTH(1)) u_i_jump (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.i_jump_D), .q(bus.i_jump_E));
   pipe_field_reg #(.WIDTH(1)) u_PC_to_ALU (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.PC_to_ALU_D), .q(bus.PC_to_ALU_E));
   pipe_field_reg #(.WIDTH(1)) u_memory_transaction (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.memory_transaction_D), .q(bus.memory_transaction_E));

   // Vector-unit controls
   pipe_field_reg #(.WIDTH(1)) u_write_vector_reg (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.write_vector_reg_D), .q(bus.write_vector_reg_E));
   pipe_field_reg #(.WIDTH(1)) u_select_operand_0_vector (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.select_operand_0_vector_D), .q(bus.select_operand_0_vector_E));
   pipe_field_reg #(.WIDTH(1)) u_select_operand_1_vector (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.select_operand_1_vector_D), .q(bus.select_operand_1_vector_E));
   pipe_field_reg #(.WIDTH(1)) u_rerouting_select (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.rerouting_select_D), .q(bus.rerouting_select_E));
   pipe_field_reg #(.WIDTH(REROUTING_CODE_W)) u_rerouting_code (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.rerouting_code_D), .q(bus.rerouting_code_E));

   pipe_field_reg #(.WIDTH(RADDR)) u_rd (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.rd_D), .q(bus.rd_E));
   pipe_field_reg #(.WIDTH(RADDR)) u_r1 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.r1_D), .q(bus.r1_E));
   pipe_field_reg #(.WIDTH(RADDR)) u_r2 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.r2_D), .q(bus.r2_E));

   // Operand data
   pipe_field_reg #(.WIDTH(XLEN)) u_scalar_reg_data_0 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.scalar_reg_data_0_D), .q(bus.scalar_reg_data_0_E));
   pipe_field_reg #(.WIDTH(XLEN)) u_scalar_reg_data_1 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.scalar_reg_data_1_D), .q(bus.scalar_reg_data_1_E));
   pipe_field_reg #(.WIDTH(VLEN)) u_vector_reg_data_0 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.vector_reg_data_0_D), .q(bus.vector_reg_data_0_E));
   pipe_field_reg #(.WIDTH(VLEN)) u_vector_reg_data_1 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.vector_reg_data_1_D), .q(bus.vector_reg_data_1_E));
   pipe_field_reg #(.WIDTH(XLEN)) u_immediate (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.immediate_D), .q(bus.immediate_E));
   pipe_field_reg #(.WIDTH(XLEN)) u_PC (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.PC_D), .q(bus.PC_E));
   pipe_field_reg #(.WIDTH(XLEN)) u_PC_plus_4 (.clock, .async_reset, .sync_clear(bus.sync_reset), .enable(bus.enabler),
      .d(bus.PC_plus_4_D), .q(bus.PC_plus_4_E));

endmodule

// File: tb/tb_pipe_execute_vp_reg.sv
// Scoreboard bench for the D->E pipeline register: predicted stage contents queued at drive time, compared after each edge.
module tb_pipe_execute_vp_reg;
   import cpu_pkg::*;

   localparam int unsigned FW = $bits(de_fields_t);

   logic clock = 1'b0;
   logic async_reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   de_fields_t cur_d;
   de_fields_t model;
   de_fields_t exp_q[$];

   pipe_execute_vp_reg_if bus ();

   pipe_execute_vp_reg dut (.clock(clock), .async_reset(async_reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic check(input string tag, input de_fields_t obs, input de_fields_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_d(input de_fields_t f);
      cur_d = f;
      bus.instruction_D             = f.instruction;
      bus.write_scalar_reg_D        = f.write_scalar_reg;
      bus.result_source_D           = f.result_source;
      bus.width_type_D              = f.width_type;
      bus.mem_write_D               = f.mem_write;
      bus.ALU_op_D                  = f.ALU_op;
      bus.cond_code_D               = f.cond_code;
      bus.ALU_source_D              = f.ALU_source;
      bus.branch_D                  = f.branch;
      bus.jump_D                    = f.jump;
      bus.i_jump_D                  = f.i_jump;
      bus.PC_to_ALU_D               = f.PC_to_ALU;
      bus.memory_transaction_D      = f.memory_transaction;
      bus.write_vector_reg_D        = f.write_vector_reg;
      bus.select_operand_0_vector_D = f.select_operand_0_vector;
      bus.select_operand_1_vector_D = f.select_operand_1_vector;
      bus.rerouting_select_D        = f.rerouting_select;
      bus.rerouting_code_D          = f.rerouting_code;
      bus.rd_D                      = f.rd;
      bus.r1_D                      = f.r1;
      bus.r2_D                      = f.r2;
      bus.scalar_reg_data_0_D       = f.scalar_reg_data_0;
      bus.scalar_reg_data_1_D       = f.scalar_reg_data_1;
      bus.vector_reg_data_0_D       = f.vector_reg_data_0;
      bus.vector_reg_data_1_D       = f.vector_reg_data_1;
      bus.immediate_D               = f.immediate;
      bus.PC_D                      = f.PC;
      bus.PC_plus_4_D               = f.PC_plus_4;
   endtask

   function automatic de_fields_t sample_e();
      de_fields_t f;
      f.instruction             = bus.instruction_E;
      f.write_scalar_reg        = bus.write_scalar_reg_E;
      f.result_source           = bus.result_source_E;
      f.width_type              = bus.width_type_E;
      f.mem_write               = bus.mem_write_E;
      f.ALU_op                  = bus.ALU_op_E;
      f.cond_code               = bus.cond_code_E;
      f.ALU_source              = bus.ALU_source_E;
      f.branch                  = bus.branch_E;
      f.jump                    = bus.jump_E;
      f.i_jump                  = bus.i_jump_E;
      f.PC_to_ALU               = bus.PC_to_ALU_E;
      f.memory_transaction      = bus.memory_transaction_E;
      f.write_vector_reg        = bus.write_vector_reg_E;
      f.select_operand_0_vector = bus.select_operand_0_vector_E;
      f.select_operand_1_vector = bus.select_operand_1_vector_E;
      f.rerouting_select        = bus.rerouting_select_E;
      f.rerouting_code          = bus.rerouting_code_E;
      f.rd                      = bus.rd_E;
      f.r1                      = bus.r1_E;
      f.r2                      = bus.r2_E;
      f.scalar_reg_data_0       = bus.scalar_reg_data_0_E;
      f.scalar_reg_data_1       = bus.scalar_reg_data_1_E;
      f.vector_reg_data_0       = bus.vector_reg_data_0_E;
      f.vector_reg_data_1       = bus.vector_reg_data_1_E;
      f.immediate               = bus.immediate_E;
      f.PC                      = bus.PC_E;
      f.PC_plus_4               = bus.PC_plus_4_E;
      return f;
   endfunction

   function automatic de_fields_t rand_fields();
      logic [FW+31:0] raw;
      raw = '0;
      for (int i = 0; i <= int'(FW / 32); i++) raw[i*32 +: 32] = $urandom;
      return de_fields_t'(raw[FW-1:0]);
   endfunction

   // Predict the stage contents after the coming edge, queue it, then compare once the edge has passed
   task automatic cycle(input string tag);
      de_fields_t p;
      if (async_reset)         p = '0;
      else if (bus.sync_reset) p = '0;
      else if (bus.enabler)    p = cur_d;
      else                     p = model;
      model = p;
      exp_q.push_back(p);
      @(posedge clock);
      #1;
      check(tag, sample_e(), exp_q.pop_front());
   endtask

   // Assert async reset between edges; outputs must clear without a clock edge
   task automatic async_clear(input string tag);
      #2;
      async_reset = 1'b1;
      model = '0;
      exp_q.push_back(model);
      #1;
      check(tag, sample_e(), exp_q.pop_front());
   endtask

   initial begin
      de_fields_t f;
      bus.sync_reset = 1'b0;
      bus.enabler    = 1'b1;

      // 1: async reset with all-ones style nonzero inputs
      f = rand_fields();
      f.instruction       = 32'hDEADBEEF;
      f.vector_reg_data_0 = {VLEN{1'b1}};
      drive_d(f);
      @(posedge clock);
      #1;
      async_clear("async_reset_immediate");
      cycle("async_reset_held_edge1");
      cycle("async_reset_held_edge2");

      // 2: first load after reset release
      async_reset = 1'b0;
      f = '0;
      f.instruction = 32'h00A00093;
      f.rd          = RADDR'(1);
      f.ALU_op      = ALU_OP_W'(4'h3);
      f.immediate   = 32'hA;
      f.PC          = 32'h100;
      f.PC_plus_4   = 32'h104;
      drive_d(f);
      cycle("load_addi");

      // 3: stall holds across three edges while inputs change
      bus.enabler = 1'b0;
      f = rand_fields();
      f.PC = 32'h200;
      drive_d(f);
      for (int i = 0; i < 3; i++) cycle($sformatf("stall_hold_%0d", i));

      // 4: flush beats stall, then reload
      bus.sync_reset = 1'b1;
      drive_d(rand_fields());
      cycle("flush_during_stall");
      bus.sync_reset = 1'b0;
      bus.enabler    = 1'b1;
      drive_d(rand_fields());
      cycle("reload_after_flush");

      // 5: vector path, full 128-bit operand
      f = '0;
      f.write_vector_reg        = 1'b1;
      f.select_operand_0_vector = 1'b1;
      f.rerouting_select        = 1'b1;
      f.rerouting_code          = 3'b101;
      f.vector_reg_data_1       = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      drive_d(f);
      cycle("vector_path");

      // 6: async reset mid-cycle while holding, outputs stay clear even with enable
      bus.enabler = 1'b0;
      drive_d(rand_fields());
      cycle("hold_before_async");
      async_clear("async_mid_hold");
      bus.enabler = 1'b1;
      drive_d(rand_fields());
      cycle("async_held_enabled_1");
      cycle("async_held_enabled_2");
      async_reset = 1'b0;
      cycle("first_load_after_release");

      // Random mix of load, stall and flush
      for (int i = 0; i < 40; i++) begin
         bus.enabler    = 1'($urandom_range(0, 3) != 0);
         bus.sync_reset = 1'($urandom_range(0, 5) == 0);
         drive_d(rand_fields());
         cycle($sformatf("random_%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_execute_vp_reg.md
Name: pipe_execute_vp_reg

Overview:
- Decode-to-execute (D->E) pipeline register of the scalar+vector RV32I-based CPU.
- Captures every decode-stage control and data signal (`*_D`) and presents it to the execute stage (`*_E`) one clock later.
- Supports a stall (hold), a synchronous flush (bubble insertion) and an asynchronous reset.
- Purely sequential: no logic transforms the data.

Parameters:
- XLEN, 32, scalar data/instruction/PC width
- VLEN, 128, vector register data width
- RADDR, 6, register index width (covers scalar and vector register files)

Ports:
- clock  in  1  pipeline clock; all captures on rising edge
- async_reset  in  1  asynchronous active-high reset; clears all outputs immediately
- sync_reset  in  1  synchronous active-high flush; clears all outputs at the next rising edge
- enabler  in  1  capture enable; 0 = stall (hold current outputs)
- instruction_D / instruction_E  in/out  XLEN  raw instruction word
- write_scalar_reg_D / _E  in/out  1  scalar register-file write enable
- result_source_D / _E  in/out  2  writeback result mux select
- width_type_D / _E  in/out  3  memory access width/sign type
- mem_write_D / _E  in/out  1  data-memory write enable
- ALU_op_D / _E  in/out  4  ALU operation code
- cond_code_D / _E  in/out  3  branch condition code
- ALU_source_D / _E  in/out  1  ALU operand-B select (register/immediate)
- branch_D, jump_D, i_jump_D / _E  in/out  1 each  branch, jump, indirect-jump flags
- PC_to_ALU_D / _E  in/out  1  ALU operand-A select (PC/register)
- memory_transaction_D / _E  in/out  1  instruction accesses memory
- write_vector_reg_D / _E  in/out  1  vector register-file write enable
- select_operand_0_vector_D, select_operand_1_vector_D / _E  in/out  1 each  operand 0/1 taken from vector file
- rerouting_select_D / _E  in/out  1  vector lane rerouting enable
- rerouting_code_D / _E  in/out  3  vector lane rerouting pattern
- rd_D, r1_D, r2_D / _E  in/out  RADDR each  destination and source register indices
- scalar_reg_data_0_D, scalar_reg_data_1_D / _E  in/out  XLEN each  scalar operands
- vector_reg_data_0_D, vector_reg_data_1_D / _E  in/out  VLEN each  vector operands
- immediate_D / _E  in/out  XLEN  sign-extended immediate
- PC_D, PC_plus_4_D / _E  in/out  XLEN each  instruction PC and PC+4

Behaviour:
- Clock and reset: single clock domain, clock; reset is asynchronous and active-high (async_reset).
- Every `*_E` output is a flop. Each `*_E` output is the registered copy of the same-named `*_D` input at full width.
- Priority, evaluated per rising edge unless async_reset is asserted:
  - async_reset=1: all outputs 0 at once, independent of clock. Outputs stay 0 while asserted.
  - else sync_reset=1: all outputs <= 0 at the edge. This holds even if enabler=0 (flush beats stall).
  - else enabler=1: all outputs <= inputs.
  - else: hold all outputs.
- Reset value of every output is 0. The cleared register is a NOP bubble: no register or memory write, no branch or jump.
- Latency: exactly 1 cycle from D capture to E visibility. No combinational path from any input to any output.
- Release of async_reset mid-cycle: the first capture occurs at the next rising edge where sync_reset=0 and enabler=1.
- Fields are never partially updated: all fields load, clear or hold together.
- No handshake beyond enabler; upstream hazard logic drives enabler and sync_reset.

Decomposition:
- Shared package cpu_pkg holds:
  - constants XLEN=32, VLEN=128, RADDR=6
  - widths of the encoded control fields: result_source 2, width_type 3, ALU_op 4, cond_code 3, rerouting_code 3
- One generic sub-module, pipe_field_reg, parameterised by WIDTH:
  - inputs d, enable, sync_clear, clock, async_reset; output q
  - instantiated once per field
- The top level is wiring only.

Test Plan:
1. async_reset=1 with all D inputs driven to nonzero values (instruction_D=32'hDEADBEEF, vector_reg_data_0_D=128'hFF..FF) -> all E outputs read 0 without waiting for a clock edge.
2. Release reset; enabler=1, sync_reset=0; drive instruction_D=32'h00A00093, rd_D=1, ALU_op_D=4'h3, immediate_D=32'hA, PC_D=32'h100, PC_plus_4_D=32'h104 -> after exactly one rising edge the E outputs equal these values and the other E outputs are 0.
3. Stall: enabler=0, change every D input (PC_D=32'h200) -> E outputs keep the case-2 values across 3 edges.
4. Flush: sync_reset=1 with enabler=0 and nonzero D inputs -> all E outputs are 0 after the next edge. When sync_reset drops with enabler=1, the next edge loads D.
5. Vector path: write_vector_reg_D=1, select_operand_0_vector_D=1, rerouting_select_D=1, rerouting_code_D=3'b101, vector_reg_data_1_D=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 -> E outputs match bit-exactly after one edge. All 128 bits are checked.
6. Async reset asserted between clock edges while holding data -> E outputs clear immediately. They remain 0 while async_reset=1 even with enabler=1.
